reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 197 +++++++++++++++++++
 tb/tb_reg_file.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - SPI-facing register file; optional watchdog selected by macro WATCHDOG_EN
module reg_file (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  address,
  input  logic        write_en,
  input  logic [7:0]  wr_data,
  input  logic        read_en,
  output logic [7:0]  rd_data,
  input  logic [7:0]  status_in,
  input  logic        fault_in,
  output logic [7:0]  ctrl_out,
  output logic [31:0] duty_out
);

  logic [7:0]  ctrl_q;
  logic [7:0]  scratch_q;
  logic [31:0] duty_q;
  logic [3:0]  fault_q;
  logic [7:0]  status_s1, status_s2;
  logic        fault_s1, fault_s2, fault_s3;
  logic        wr_ok, rd_ok, conflict;
  logic        addr_rw, addr_w1c, addr_ignored;
  logic        bad_write, fault_edge, expire;
  logic [3:0]  fault_set, fault_clr;
  logic [7:0]  rd_mux;

  // A simultaneous read and write strobe is treated as a protocol error: neither is performed
  assign conflict   = write_en & read_en;
  assign wr_ok      = write_en & ~read_en;
  assign rd_ok      = read_en & ~write_en;
  assign fault_edge = fault_s2 & ~fault_s3;

  // Classify the addressed location for writes
  always_comb begin
    addr_rw      = 1'b0;
    addr_w1c     = 1'b0;
    addr_ignored = 1'b0;
    case (address)
      6'h01, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B: addr_rw = 1'b1;
      6'h03: addr_w1c = 1'b1;
`ifdef WATCHDOG_EN
      6'h04: addr_rw = 1'b1;
`else
      6'h04: addr_ignored = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bad_write = wr_ok & ~addr_rw & ~addr_w1c & ~addr_ignored;

`ifdef WATCHDOG_EN
  typedef enum logic [1:0] {WDT_DISABLED, WDT_RUN, WDT_EXPIRED} wdt_state_t;

  wdt_state_t  wdt_state, wdt_state_nxt;
  logic [15:0] wdt_cnt, wdt_cnt_nxt;
  logic [7:0]  wdt_limit_q;
  logic        limit_zero_wr;

  assign limit_zero_wr = wr_ok && (address == 6'h04) && (wr_data == 8'h00);

  // Watchdog state and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdt_state <= WDT_DISABLED;
      wdt_cnt   <= 16'h0000;
    end else begin
      wdt_state <= wdt_state_nxt;
      wdt_cnt   <= wdt_cnt_nxt;
    end
  end

  // Watchdog next state: any write strobe restarts the count and beats a same-cycle expiry
  always_comb begin
    wdt_state_nxt = wdt_state;
    wdt_cnt_nxt   = wdt_cnt;
    expire        = 1'b0;
    case (wdt_state)
      WDT_DISABLED: begin
        wdt_cnt_nxt = 16'h0000;
        if (wdt_limit_q != 8'h00) wdt_state_nxt = WDT_RUN;
      end
      WDT_RUN: begin
        if (write_en) begin
          wdt_cnt_nxt = 16'h0000;
        end else if (wdt_cnt == {wdt_limit_q, 8'hFF}) begin
          wdt_state_nxt = WDT_EXPIRED;
          wdt_cnt_nxt   = 16'h0000;
          expire        = 1'b1;
        end else begin
          wdt_cnt_nxt = wdt_cnt + 16'd1;
        end
      end
      WDT_EXPIRED: begin
        wdt_cnt_nxt = 16'h0000;
        if (write_en) wdt_state_nxt = WDT_RUN;
      end
      default: begin
        wdt_state_nxt = WDT_DISABLED;
        wdt_cnt_nxt   = 16'h0000;
      end
    endcase
    if (limit_zero_wr) begin
      wdt_state_nxt = WDT_DISABLED;
      wdt_cnt_nxt   = 16'h0000;
      expire        = 1'b0;
    end
  end

  // Watchdog limit register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wdt_limit_q <= 8'h00;
    else if (wr_ok && address == 6'h04) wdt_limit_q <= wr_data;
  end
`else
  assign expire = 1'b0;
`endif

  // Two-flop synchronizers for status and fault, plus one extra fault stage for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status_s1 <= 8'h00;
      status_s2 <= 8'h00;
      fault_s1  <= 1'b0;
      fault_s2  <= 1'b0;
      fault_s3  <= 1'b0;
    end else begin
      status_s1 <= status_in;
      status_s2 <= status_s1;
      fault_s1  <= fault_in;
      fault_s2  <= fault_s1;
      fault_s3  <= fault_s2;
    end
  end

  // Control-plane registers; an expiry wipes the actuator outputs (never coincides with a write)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= 8'h00;
      scratch_q <= 8'h00;
      duty_q    <= 32'h0;
    end else if (expire) begin
      ctrl_q <= 8'h00;
      duty_q <= 32'h0;
    end else if (wr_ok) begin
      case (address)
        6'h01: ctrl_q          <= wr_data;
        6'h05: scratch_q       <= wr_data;
        6'h08: duty_q[7:0]     <= wr_data;
        6'h09: duty_q[15:8]    <= wr_data;
        6'h0A: duty_q[23:16]   <= wr_data;
        6'h0B: duty_q[31:24]   <= wr_data;
        default: ;
      endcase
    end
  end

  assign fault_set = {conflict, bad_write, expire, fault_edge};
  assign fault_clr = (wr_ok && addr_w1c) ? wr_data[3:0] : 4'h0;

  // Sticky fault bits: write-one-to-clear, with a same-cycle set taking priority
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 4'h0;
    else          fault_q <= (fault_q & ~fault_clr) | fault_set;
  end

  // Read multiplexer over the current register contents
  always_comb begin
    rd_mux = 8'h00;
    case (address)
      6'h00: rd_mux = 8'hA5;
      6'h01: rd_mux = ctrl_q;
      6'h02: rd_mux = status_s2;
      6'h03: rd_mux = {4'h0, fault_q};
`ifdef WATCHDOG_EN
      6'h04: rd_mux = wdt_limit_q;
`endif
      6'h05: rd_mux = scratch_q;
      6'h08: rd_mux = duty_q[7:0];
      6'h09: rd_mux = duty_q[15:8];
      6'h0A: rd_mux = duty_q[23:16];
      6'h0B: rd_mux = duty_q[31:24];
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data, held between read strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   rd_data <= 8'h00;
    else if (rd_ok) rd_data <= rd_mux;
  end

  assign ctrl_out = ctrl_q;
  assign duty_out = duty_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against a behavioural model
module tb_reg_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  address;
  logic        write_en;
  logic [7:0]  wr_data;
  logic        read_en;
  logic [7:0]  rd_data;
  logic [7:0]  status_in;
  logic        fault_in;
  logic [7:0]  ctrl_out;
  logic [31:0] duty_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] st_drv = 8'h00;
  logic       flt_drv = 1'b0;
  bit         chk_en = 1'b1;

  // behavioural model
  logic [7:0] m_ctrl, m_scratch, m_limit, m_rd;
  logic [3:0] m_fault;
  logic [7:0] m_duty [4];
  logic [7:0] st_q [$];
  logic       f_q [$];

  reg_file dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write_en(write_en),
    .wr_data(wr_data), .read_en(read_en), .rd_data(rd_data), .status_in(status_in),
    .fault_in(fault_in), .ctrl_out(ctrl_out), .duty_out(duty_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_scratch = 0; m_limit = 0; m_rd = 0; m_fault = 0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    st_q = '{8'h00, 8'h00};
    f_q  = '{1'b0, 1'b0, 1'b0};
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a, input logic [7:0] stat);
    case (a)
      6'h00: return 8'hA5;
      6'h01: return m_ctrl;
      6'h02: return stat;
      6'h03: return {4'h0, m_fault};
      6'h04: return m_limit;
      6'h05: return m_scratch;
      6'h08, 6'h09, 6'h0A, 6'h0B: return m_duty[int'(a) - 8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge(input logic [5:0] a, input logic we, input logic [7:0] wd,
                            input logic re, input logic [7:0] s, input logic f);
    logic [7:0] stat;
    logic       fe;
    logic [3:0] set, clr;
    stat = st_q[0];
    fe   = f_q[1] & ~f_q[0];
    void'(st_q.pop_front()); st_q.push_back(s);
    void'(f_q.pop_front());  f_q.push_back(f);
    set = 0; clr = 0;
    if (we && re) set[3] = 1'b1;
    else begin
      if (re) m_rd = m_read(a, stat);
      if (we) begin
        if (a == 6'h01) m_ctrl = wd;
        else if (a == 6'h05) m_scratch = wd;
        else if (a >= 6'h08 && a <= 6'h0B) m_duty[int'(a) - 8] = wd;
        else if (a == 6'h03) clr = wd[3:0];
        else if (a == 6'h04) begin
`ifdef WATCHDOG_EN
          m_limit = wd;
`endif
        end
        else set[2] = 1'b1;
      end
    end
    if (fe) set[0] = 1'b1;
    m_fault = (m_fault & ~clr) | set;
  endtask

  task automatic step(input logic [5:0] a, input logic we, input logic [7:0] wd, input logic re);
    @(negedge clock);
    address = a; write_en = we; wr_data = wd; read_en = re;
    status_in = st_drv; fault_in = flt_drv;
    @(posedge clock);
    model_edge(a, we, wd, re, st_drv, flt_drv);
    #1;
    if (chk_en) begin
      check("rd_data", rd_data, m_rd);
      check("ctrl_out", ctrl_out, m_ctrl);
      check("duty_out", duty_out, {m_duty[3], m_duty[2], m_duty[1], m_duty[0]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; write_en = 0; read_en = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = 0; write_en = 0; wr_data = 0; read_en = 0;
    status_in = 0; fault_in = 0;
    model_reset();
    st_drv = 8'h96;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rd", rd_data, 8'h00);
    check("reset_ctrl", ctrl_out, 8'h00);
    check("reset_duty", duty_out, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // ID read
    step(6'h00, 1'b0, 8'h00, 1'b1);
    check("id_read", rd_data, 8'hA5);

    // DUTY1 write and read back
    step(6'h09, 1'b1, 8'h3C, 1'b0);
    check("duty1_out", duty_out[15:8], 8'h3C);
    step(6'h09, 1'b0, 8'h00, 1'b1);
    check("duty1_read", rd_data, 8'h3C);

    // write to RO STATUS flags FAULT[2], W1C clears it
    step(6'h02, 1'b1, 8'h55, 1'b0);
    step(6'h03, 1'b0, 8'h00, 1'b1);
    check("fault_ro_wr", rd_data, 8'h04);
    step(6'h02, 1'b0, 8'h00, 1'b1);
    check("status_read", rd_data, 8'h96);
    step(6'h03, 1'b1, 8'h04, 1'b0);
    step(6'h03, 1'b0, 8'h00, 1'b1);
    check("fault_w1c", rd_data, 8'h00);

    // fault edge arrives in the same cycle as a clear of bit 0: set wins
    flt_drv = 1'b1; idle(1);
    flt_drv = 1'b0; idle(1);
    step(6'h03, 1'b1, 8'h01, 1'b0);
    step(6'h03, 1'b0, 8'h00, 1'b1);
    check("fault_set_wins", rd_data, 8'h01);
    step(6'h03, 1'b1, 8'h0F, 1'b0);

    // simultaneous read+write strobes
    step(6'h05, 1'b1, 8'h77, 1'b1);
    step(6'h03, 1'b0, 8'h00, 1'b1);
    check("fault_conflict", rd_data, 8'h08);
    step(6'h05, 1'b0, 8'h00, 1'b1);
    check("conflict_no_wr", rd_data, 8'h00);
    step(6'h03, 1'b1, 8'h0F, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] a;
      logic       we, re;
      int         r;
      r  = $urandom_range(0, 3);
      a  = (r == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
      we = ($urandom_range(0, 9) < 4);
      re = ($urandom_range(0, 9) < 4);
`ifdef WATCHDOG_EN
      if (we && a == 6'h04) a = 6'h05;
`endif
      st_drv  = 8'($urandom);
      flt_drv = ($urandom_range(0, 3) == 0) ? ~flt_drv : flt_drv;
      step(a, we, 8'($urandom), re);
    end
    flt_drv = 1'b0;
    idle(4);

`ifdef WATCHDOG_EN
    // watchdog expiry after 512 idle cycles with limit 1
    do_reset();
    step(6'h04, 1'b1, 8'h01, 1'b0);
    step(6'h08, 1'b1, 8'h11, 1'b0);
    step(6'h01, 1'b1, 8'hFF, 1'b0);
    chk_en = 1'b0;
    idle(511);
    check("wdt_before", ctrl_out, 8'hFF);
    idle(1);
    check("wdt_expire_ctrl", ctrl_out, 8'h00);
    check("wdt_expire_duty", duty_out, 32'h0);
    step(6'h03, 1'b0, 8'h00, 1'b1);
    check("wdt_fault1", rd_data, 8'h02);
    // write on the terminal-count cycle beats expiry
    step(6'h01, 1'b1, 8'hFF, 1'b0);
    idle(511);
    step(6'h01, 1'b1, 8'h42, 1'b0);
    check("wdt_term_wr", ctrl_out, 8'h42);
    idle(5);
    check("wdt_no_expire", ctrl_out, 8'h42);
    // limit 0 disables
    step(6'h04, 1'b1, 8'h00, 1'b0);
    idle(600);
    check("wdt_disabled", ctrl_out, 8'h42);
`endif

    // asynchronous reset mid-operation
    do_reset();
`ifdef WATCHDOG_EN
    step(6'h04, 1'b1, 8'h01, 1'b0);
`endif
    step(6'h01, 1'b1, 8'h81, 1'b0);
    step(6'h0B, 1'b1, 8'h5A, 1'b0);
    step(6'h01, 1'b0, 8'h00, 1'b1);
    idle(20);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_out, 8'h00);
    check("async_rst_duty", duty_out, 32'h0);
    check("async_rst_rd", rd_data, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    step(6'h01, 1'b1, 8'h81, 1'b0);
    idle(600);
    check("post_rst_ctrl", ctrl_out, 8'h81);
    step(6'h04, 1'b0, 8'h00, 1'b1);
    check("post_rst_limit", rd_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
